// File: rtl/ddr3_app_pkg.sv
// Encodings shared by the DDR3 app-interface arbiter and its testbench.
package ddr3_app_pkg;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ddr3_app_id_fifo.sv
// First-word-fall-through FIFO holding requester ids of reads in flight.
module ddr3_app_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddr3_app_arb.sv
// Round-robin arbiter sharing one MIG DDR3 app interface between NUM_REQ
// requesters; in-order read data is steered back through an id FIFO.
module ddr3_app_arb
    import ddr3_app_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 512,
    parameter int MASK_WIDTH     = 64,
    parameter int RD_OUTSTANDING = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 init_calib_complete,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0]                   req_rnw,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0][MASK_WIDTH-1:0]   req_wmask,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic [ADDR_WIDTH-1:0]                app_addr,
    output logic [2:0]                           app_cmd,
    output logic                                 app_en,
    input  logic                                 app_rdy,
    output logic [DATA_WIDTH-1:0]                app_wdf_data,
    output logic [MASK_WIDTH-1:0]                app_wdf_mask,
    output logic                                 app_wdf_wren,
    output logic                                 app_wdf_end,
    input  logic                                 app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]                app_rd_data,
    input  logic                                 app_rd_data_valid,
    input  logic                                 app_rd_data_end
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = $clog2(RD_OUTSTANDING) + 1;

    typedef struct packed {
        logic                  rnw;
        logic [ID_W-1:0]       id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] wmask;
    } cmd_t;

    arb_state_e       state, state_nxt;
    cmd_t             cmd_q;
    logic [ID_W-1:0]  rr_ptr, grant_id, id_head;
    logic [NUM_REQ-1:0] elig;
    logic             grant_vld, can_grant;
    logic             cmd_done, data_done, cmd_done_nxt, data_done_nxt;
    logic             cmd_acc, data_acc, rsp_fire;
    logic             id_full, id_empty, err_underflow;
    logic [CW-1:0]    id_count;
    logic             unused_ok;

    assign elig = req_valid & ~(req_rnw & {NUM_REQ{id_full}});

    // rr_ptr is where the next search begins: one past the last winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // rst_n gate keeps req_ready low while reset holds the FSM in IDLE.
    assign can_grant = rst_n && (state == ST_IDLE) && init_calib_complete && grant_vld;
    assign req_ready = can_grant ? (NUM_REQ'(1) << grant_id) : '0;

    assign app_en       = (state == ST_ISSUE) && !cmd_done;
    assign app_wdf_wren = (state == ST_ISSUE) && !cmd_q.rnw && !data_done;
    assign app_wdf_end  = app_wdf_wren;
    assign app_cmd      = cmd_q.rnw ? APP_CMD_RD : APP_CMD_WR;
    assign app_addr     = cmd_q.addr;
    assign app_wdf_data = cmd_q.wdata;
    assign app_wdf_mask = cmd_q.wmask;
    assign cmd_acc      = app_en && app_rdy;
    assign data_acc     = app_wdf_wren && app_wdf_rdy;

    always_comb begin
        state_nxt     = state;
        cmd_done_nxt  = cmd_done;
        data_done_nxt = data_done;
        case (state)
            ST_IDLE: begin
                if (can_grant) begin
                    state_nxt     = ST_ISSUE;
                    cmd_done_nxt  = 1'b0;
                    data_done_nxt = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (cmd_acc)  cmd_done_nxt  = 1'b1;
                if (data_acc) data_done_nxt = 1'b1;
                if ((cmd_done || cmd_acc) && (cmd_q.rnw || data_done || data_acc)) begin
                    state_nxt     = ST_IDLE;
                    cmd_done_nxt  = 1'b0;
                    data_done_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            cmd_q         <= '0;
            cmd_done      <= 1'b0;
            data_done     <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_done  <= cmd_done_nxt;
            data_done <= data_done_nxt;
            if (can_grant) begin
                rr_ptr <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
                cmd_q  <= '{rnw:   req_rnw[grant_id],
                            id:    grant_id,
                            addr:  req_addr[grant_id],
                            wdata: req_wdata[grant_id],
                            wmask: req_wmask[grant_id]};
            end
            if (app_rd_data_valid && id_empty) err_underflow <= 1'b1;
        end
    end

    ddr3_app_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (RD_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_acc && cmd_q.rnw),
        .pop   (app_rd_data_valid),
        .din   (cmd_q.id),
        .dout  (id_head),
        .full  (id_full),
        .empty (id_empty),
        .count (id_count)
    );

    // Stray read data with no read outstanding is dropped, not routed.
    assign rsp_fire  = app_rd_data_valid && !id_empty;
    assign rsp_valid = rsp_fire ? (NUM_REQ'(1) << id_head) : '0;
    assign rsp_data  = rsp_fire ? app_rd_data : '0;

    assign unused_ok = ^{app_rd_data_end, id_count, err_underflow};

endmodule

// File: tb/tb_ddr3_app_arb.sv
// Bench for ddr3_app_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_ddr3_app_arb;
    localparam int N = 2, AW = 28, DW = 512, MW = 64, RO = 16;

    logic clk = 1'b0, rst_n = 1'b0, calib = 1'b0;
    logic [N-1:0]         req_valid = '0, req_rnw = '0, req_ready, rsp_valid;
    logic [N-1:0][AW-1:0] req_addr  = '0;
    logic [N-1:0][DW-1:0] req_wdata = '0;
    logic [N-1:0][MW-1:0] req_wmask = '0;
    logic [DW-1:0] rsp_data, app_wdf_data, app_rd_data = '0;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic [MW-1:0] app_wdf_mask;
    logic app_en, app_wdf_wren, app_wdf_end;
    logic app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0, app_rd_data_end = 1'b0;

    ddr3_app_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                   .RD_OUTSTANDING(RO)) dut (
        .clk(clk), .rst_n(rst_n), .init_calib_complete(calib),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Transaction-level model: one command in flight, list of read ids owed data.
    bit            m_busy = 0, m_rnw = 0, m_cd = 0, m_dd = 0;
    int            m_rr = 0, m_id = 0, idx = 0;
    int            m_idq[$];
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [MW-1:0] m_mask = '0;
    logic [N-1:0]  exp_ready, exp_rsp, took = '0;
    bit            exp_en, exp_wren;
    logic [DW-1:0] mig_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_rr = 0; m_cd = 0; m_dd = 0; took = '0;
            m_idq.delete();
            chk("m_reset_outs", {req_ready, app_en, app_wdf_wren, rsp_valid}, '0);
        end else begin
            exp_ready = '0;
            if (!m_busy && calib)
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (exp_ready == '0 && req_valid[idx] && (!req_rnw[idx] || m_idq.size() < RO))
                        exp_ready[idx] = 1'b1;
                end
            exp_en   = m_busy && !m_cd;
            exp_wren = m_busy && !m_rnw && !m_dd;
            exp_rsp  = '0;
            if (app_rd_data_valid && m_idq.size() > 0) exp_rsp[m_idq[0]] = 1'b1;
            chk("m_req_ready", req_ready, exp_ready);
            chk("m_app_en", app_en, exp_en);
            chk("m_wdf_wren_end", {app_wdf_wren, app_wdf_end}, {exp_wren, exp_wren});
            if (exp_en) chk("m_cmd_addr", {app_cmd, app_addr}, {(m_rnw ? 3'b001 : 3'b000), m_addr});
            if (exp_wren) chk("m_wdf_data_mask", {app_wdf_mask, app_wdf_data[DW-MW-1:0]},
                              {m_mask, m_wdata[DW-MW-1:0]});
            chk("m_rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp != '0) chk("m_rsp_data", rsp_data, app_rd_data);
            // environment: acceptances seen by requesters and by the memory
            took = req_valid & req_ready;
            if (app_en && app_rdy && app_cmd == 3'b001) mig_q.push_back(rnd512());
            // advance the model across the coming edge
            if (exp_rsp != '0) void'(m_idq.pop_front());
            if (m_busy) begin
                if (exp_en && app_rdy) begin
                    m_cd = 1;
                    if (m_rnw) m_idq.push_back(m_id);
                end
                if (exp_wren && app_wdf_rdy) m_dd = 1;
                if (m_cd && (m_rnw || m_dd)) m_busy = 0;
            end else if (exp_ready != '0) begin
                for (int k = 0; k < N; k++) if (exp_ready[k]) m_id = k;
                m_rnw = req_rnw[m_id]; m_addr = req_addr[m_id];
                m_wdata = req_wdata[m_id]; m_mask = req_wmask[m_id];
                m_busy = 1; m_cd = 0; m_dd = 0;
                m_rr = (m_id + 1) % N;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic new_req(input int i, input int rd_pct);
        req_rnw[i]   = ($urandom % 100) < rd_pct;
        req_addr[i]  = AW'($urandom);
        req_wdata[i] = rnd512();
        req_wmask[i] = {$urandom, $urandom};
    endtask

    task automatic rand_cycles(input int ncyc, input int rd_pct, input int ret_pct, input int vld_pct);
        for (int c = 0; c < ncyc; c++) begin
            cyc();
            for (int i = 0; i < N; i++)
                if (took[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom % 100) < vld_pct;
                    if (req_valid[i]) new_req(i, rd_pct);
                end
            calib       = ($urandom % 40) != 0;
            app_rdy     = ($urandom % 3) != 0;
            app_wdf_rdy = ($urandom % 3) != 0;
            if (mig_q.size() > 0 && ($urandom % 100) < ret_pct) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = mig_q.pop_front();
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data = rnd512();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    logic [7:0] seq;
    int ng;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_en_wren", {app_en, app_wdf_wren, app_wdf_end}, 0);
        chk("reset_rsp", rsp_valid, 0);
        chk("reset_cmd_addr", {app_cmd, app_addr}, 0);
        chk("reset_count_err", {dut.id_count, dut.err_underflow}, 0);
        cyc(); rst_n = 1'b1;

        // single read from req0
        cyc(); calib = 1; req_valid = 2'b01; req_rnw = 2'b01; req_addr[0] = 28'h100;
        @(negedge clk); chk("rd_ready", req_ready, 2'b01);
        cyc(); req_valid = 0; app_rdy = 1;
        @(negedge clk); chk("rd_cmd", {app_en, app_cmd, app_addr}, {1'b1, 3'b001, 28'h100});
        cyc(); @(negedge clk);
        chk("rd_en_drop", app_en, 0); chk("rd_count", dut.id_count, 1);
        repeat (3) cyc();
        app_rd_data_valid = 1; app_rd_data = {64{8'hA5}};
        @(negedge clk); chk("rd_rsp_valid", rsp_valid, 2'b01); chk("rd_rsp_data", rsp_data, {64{8'hA5}});
        cyc(); app_rd_data_valid = 0;
        @(negedge clk); chk("rd_count_empty", dut.id_count, 0);

        // write from req1 with data handshake 3 cycles behind the command
        cyc(); req_valid = 2'b10; req_rnw = 2'b00; req_addr[1] = 28'h200;
        req_wdata[1] = {16{32'hDEADBEEF}}; req_wmask[1] = 64'hF0; app_wdf_rdy = 0;
        @(negedge clk); chk("wr_ready", req_ready, 2'b10);
        cyc(); req_valid = 0;
        @(negedge clk);
        chk("wr_issue", {app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr}, {3'b111, 3'b000, 28'h200});
        chk("wr_data", {app_wdf_mask, app_wdf_data}, {64'hF0, {16{32'hDEADBEEF}}});
        cyc(); @(negedge clk); chk("wr_en_drop", {app_en, app_wdf_wren}, 2'b01);
        cyc(); @(negedge clk); chk("wr_wren_hold3", app_wdf_wren, 1);
        cyc(); app_wdf_rdy = 1;
        @(negedge clk); chk("wr_wren_hold4", app_wdf_wren, 1);
        cyc(); @(negedge clk); chk("wr_done", {app_en, app_wdf_wren}, 2'b00);

        // both requesters continuously valid: grants must alternate 0,1,0,1...
        cyc(); req_valid = 2'b11; req_rnw = 2'b00;
        seq = '0; ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin seq[ng] = req_ready[1]; ng++; end
        end
        cyc(); req_valid = 0;
        chk("rr_grant_count", ng, 8);
        chk("rr_order", seq, 8'b1010_1010);
        cyc(); cyc();

        // fill the id FIFO with reads from req0, no data returning
        cyc(); req_valid = 2'b01; req_rnw = 2'b01; req_addr[0] = 28'h300;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dut.id_count == 16) break;
        end
        chk("full_count", dut.id_count, 16);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("full_no_rd_grant", req_ready, 0);
        end
        cyc(); req_valid = 2'b11; req_addr[1] = 28'h400;
        @(negedge clk); chk("full_wr_grant", req_ready, 2'b10);
        cyc(); req_valid = 2'b01;
        repeat (2) cyc();
        @(negedge clk); chk("full_still_blocked", req_ready, 0);
        cyc(); app_rd_data_valid = 1; app_rd_data = {16{32'h5A5A0001}};
        @(negedge clk); chk("full_pop_rsp", {rsp_valid, rsp_data}, {2'b01, {16{32'h5A5A0001}}});
        cyc(); app_rd_data_valid = 0;
        @(negedge clk); chk("slot_free_grant", req_ready, 2'b01);
        cyc(); req_valid = 0;
        cyc(); cyc();
        app_rd_data_valid = 1;
        repeat (16) cyc();
        app_rd_data_valid = 0;
        @(negedge clk); chk("drain_count", dut.id_count, 0);

        // reset mid-ISSUE with one read outstanding
        cyc(); req_valid = 2'b01; req_rnw = 2'b01; req_addr[0] = 28'h500; app_rdy = 1;
        @(negedge clk);
        cyc(); req_valid = 0;
        cyc(); app_rdy = 0; req_valid = 2'b01; req_addr[0] = 28'h600;
        @(negedge clk); chk("rst_pre_grant", req_ready, 2'b01);
        cyc(); req_valid = 0;
        @(negedge clk); chk("rst_pre_issue", {app_en, dut.id_count}, {1'b1, 5'd1});
        cyc(); rst_n = 0; calib = 0; req_valid = 2'b01;
        #1;
        chk("rst_async_outs", {app_en, req_ready, rsp_valid}, 0);
        chk("rst_async_count", dut.id_count, 0);
        @(negedge clk);
        cyc(); rst_n = 1; req_valid = 0;
        cyc(); calib = 1; req_valid = 2'b01; req_addr[0] = 28'h700; app_rdy = 1;
        @(negedge clk); chk("post_rst_grant", req_ready, 2'b01);
        cyc(); req_valid = 0;
        @(negedge clk); chk("post_rst_cmd", {app_en, app_cmd, app_addr}, {1'b1, 3'b001, 28'h700});
        cyc(); @(negedge clk); chk("post_rst_count", dut.id_count, 1);
        cyc(); app_rd_data_valid = 1; app_rd_data = {16{32'h0BADF00D}};
        @(negedge clk); chk("post_rst_rsp", rsp_valid, 2'b01);
        cyc(); app_rd_data_valid = 0;

        // read data with nothing outstanding is dropped and flagged
        cyc(); app_rd_data_valid = 1;
        @(negedge clk); chk("underflow_rsp", rsp_valid, 0);
        cyc(); app_rd_data_valid = 0;
        @(negedge clk); chk("underflow_flag", dut.err_underflow, 1);

        // randomized traffic: mixed, then read-heavy with slow returns, then drain
        mig_q.delete();
        rand_cycles(1500, 50, 40, 60);
        rand_cycles(1000, 90, 2, 80);
        rand_cycles(300, 0, 100, 0);
        @(negedge clk);
        chk("final_count", dut.id_count, 0);
        chk("final_mig_empty", mig_q.size(), 0);
        chk("final_model_empty", m_idq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
